// File: rtl/vm_pkg.sv
// ------------------------------------------------------------------
// vm_pkg: coin codes, dispenser state encoding and change width.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package vm_pkg;

   localparam int CHANGE_W = 3;

   localparam logic [1:0] COIN_ONE  = 2'b00;
   localparam logic [1:0] COIN_TWO  = 2'b01;
   localparam logic [1:0] COIN_FIVE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2,
      ST_FAULT = 2'd3
   } disp_state_e;

   // Largest coin the dispenser may issue; five-unit coins are never paid out.
   function automatic logic [1:0] coin_for(input logic [CHANGE_W-1:0] rem);
      return (rem >= 3'd2) ? COIN_TWO : COIN_ONE;
   endfunction

   function automatic logic [CHANGE_W-1:0] coin_value(input logic [1:0] code);
      logic [CHANGE_W-1:0] val;
      case (code)
         COIN_TWO:  val = 3'd2;
         COIN_FIVE: val = 3'd5;
         default:   val = 3'd1;
      endcase
      return val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vm_timeout_ctr.sv
// ------------------------------------------------------------------
// vm_timeout_ctr: 8-bit hopper wait counter flagging when TIMEOUT is reached.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module vm_timeout_ctr #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end
   end

   // Asserted in the cycle whose unacknowledged increment would reach TIMEOUT.
   assign expired = enable && !clear && (({1'b0, count_q} + 9'd1) >= 9'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/vm_change_dispenser.sv
// ------------------------------------------------------------------
// vm_change_dispenser: pays change as 2-unit then 1-unit coins over valid/ack.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module vm_change_dispenser
   import vm_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   input  logic [CHANGE_W-1:0] req_amount,
   output logic                coin_valid,
   output logic [1:0]          coin_code,
   input  logic                coin_ack,
   output logic                busy,
   output logic                done,
   output logic                fault,
   output logic                overflow,
   input  logic                fault_clr
);

   disp_state_e         state_q, state_d;
   logic [CHANGE_W-1:0] remaining_q, remaining_d;
   logic [CHANGE_W-1:0] pend_amt_q, pend_amt_d;
   logic                pend_full_q, pend_full_d;
   logic                coin_valid_q, coin_valid_d;
   logic [1:0]          coin_code_q, coin_code_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                fault_q, fault_d;
   logic                overflow_q, overflow_d;

   logic                req_nz;
   logic                capture;
   logic                drop;
   logic [CHANGE_W-1:0] rem_after;
   logic                ctr_clear;
   logic                ctr_enable;
   logic                ctr_expired;

   assign req_nz     = req_valid && (req_amount != '0);
   assign rem_after  = remaining_q - coin_value(coin_code_q);
   assign ctr_clear  = (state_q != ST_ISSUE) || coin_ack;
   assign ctr_enable = (state_q == ST_ISSUE) && !coin_ack;

   vm_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (ctr_clear),
      .enable  (ctr_enable),
      .expired (ctr_expired)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      pend_full_d = pend_full_q;
      pend_amt_d  = pend_amt_q;
      done_d      = 1'b0;
      capture     = 1'b0;
      drop        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_nz) begin
               remaining_d = req_amount;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (coin_ack) begin
               if (rem_after != '0) begin
                  remaining_d = rem_after;
                  state_d     = ST_GAP;
                  capture     = 1'b1;
               end else begin
                  // Request complete: chain straight into a pended or coincident request.
                  done_d = 1'b1;
                  if (pend_full_q) begin
                     remaining_d = pend_amt_q;
                     pend_full_d = 1'b0;
                     pend_amt_d  = '0;
                     drop        = req_nz;
                  end else if (req_nz) begin
                     remaining_d = req_amount;
                  end else begin
                     remaining_d = '0;
                     state_d     = ST_IDLE;
                  end
               end
            end else if (ctr_expired) begin
               state_d     = ST_FAULT;
               remaining_d = '0;
               pend_full_d = 1'b0;
               pend_amt_d  = '0;
            end else begin
               capture = 1'b1;
            end
         end
         ST_GAP: begin
            state_d = ST_ISSUE;
            capture = 1'b1;
         end
         ST_FAULT: begin
            remaining_d = '0;
            pend_full_d = 1'b0;
            pend_amt_d  = '0;
            if (fault_clr) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (capture && req_nz) begin
         if (pend_full_q) begin
            drop = 1'b1;
         end else begin
            pend_full_d = 1'b1;
            pend_amt_d  = req_amount;
         end
      end

      overflow_d   = (overflow_q && !fault_clr) || drop;
      coin_valid_d = (state_d == ST_ISSUE);
      coin_code_d  = (state_d == ST_ISSUE) ? coin_for(remaining_d) : coin_code_q;
      busy_d       = (state_d != ST_IDLE);
      fault_d      = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         remaining_q  <= '0;
         pend_full_q  <= 1'b0;
         pend_amt_q   <= '0;
         coin_valid_q <= 1'b0;
         coin_code_q  <= COIN_ONE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fault_q      <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         pend_full_q  <= pend_full_d;
         pend_amt_q   <= pend_amt_d;
         coin_valid_q <= coin_valid_d;
         coin_code_q  <= coin_code_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
         overflow_q   <= overflow_d;
      end
   end

   assign coin_valid = coin_valid_q;
   assign coin_code  = coin_code_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vm_change_dispenser.sv
// ------------------------------------------------------------------
// tb_vm_change_dispenser: directed scenarios checked against a payout model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vm_change_dispenser;

   localparam int unsigned TO = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [2:0] req_amount = 3'd0;
   logic       coin_valid;
   logic [1:0] coin_code;
   logic       coin_ack;
   logic       busy;
   logic       done;
   logic       fault;
   logic       overflow;
   logic       fault_clr = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vm_change_dispenser #(
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_amount (req_amount),
      .coin_valid (coin_valid),
      .coin_code  (coin_code),
      .coin_ack   (coin_ack),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .overflow   (overflow),
      .fault_clr  (fault_clr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Hopper: acks a coin after it has been requested for more than hop_mode cycles (-1 = never).
   int   hop_mode = 1;
   int   cv_cnt = 0;
   logic hop_ack = 1'b0;
   logic ack_force = 1'b0;
   assign coin_ack = hop_ack | ack_force;

   always @(posedge clk) begin
      #2;
      if (!coin_valid || hop_ack) cv_cnt = 0;
      if (coin_valid) cv_cnt++;
      hop_ack = coin_valid && (hop_mode >= 0) && (cv_cnt > hop_mode);
   end

   // Payout model: amount owed, one pending amount, gap flag, unacked wait cycles.
   int m_rem = 0, m_pend = 0, m_wait = 0;
   bit m_gap = 0, m_flt = 0, m_ovf = 0, m_dn = 0;

   task automatic model_reset();
      m_rem = 0; m_pend = 0; m_wait = 0;
      m_gap = 0; m_flt = 0; m_ovf = 0; m_dn = 0;
   endtask

   task automatic model_step();
      bit nz, drop;
      int coin;
      nz   = req_valid && (req_amount != 0);
      drop = 0;
      m_dn = 0;
      if (m_flt) begin
         if (fault_clr) m_flt = 0;
      end else if (m_rem == 0) begin
         if (nz) begin m_rem = int'(req_amount); m_gap = 0; m_wait = 0; end
      end else if (m_gap) begin
         m_gap = 0; m_wait = 0;
         if (nz) begin if (m_pend == 0) m_pend = int'(req_amount); else drop = 1; end
      end else begin
         coin = (m_rem >= 2) ? 2 : 1;
         if (coin_ack) begin
            m_rem  = m_rem - coin;
            m_wait = 0;
            if (nz) begin if (m_pend == 0) m_pend = int'(req_amount); else drop = 1; end
            if (m_rem == 0) begin
               m_dn = 1;
               if (m_pend != 0) begin m_rem = m_pend; m_pend = 0; end
            end else begin
               m_gap = 1;
            end
         end else begin
            m_wait++;
            if (m_wait >= int'(TO)) begin
               m_flt = 1; m_rem = 0; m_pend = 0;
            end else if (nz) begin
               if (m_pend == 0) m_pend = int'(req_amount); else drop = 1;
            end
         end
      end
      if (fault_clr) m_ovf = 0;
      if (drop) m_ovf = 1;
   endtask

   always @(negedge rst_n) model_reset();
   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   logic [1:0] coin_log[$];
   int         done_cnt = 0;

   always @(negedge clk) begin
      bit m_cv;
      m_cv = (m_rem != 0) && !m_gap && !m_flt;
      chk("coin_valid", 32'(coin_valid), 32'(m_cv));
      if (m_cv) chk("coin_code", 32'(coin_code), (m_rem >= 2) ? 32'd1 : 32'd0);
      chk("busy", 32'(busy), 32'((m_rem != 0) || m_flt));
      chk("done", 32'(done), 32'(m_dn));
      chk("fault", 32'(fault), 32'(m_flt));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (coin_valid && coin_ack) coin_log.push_back(coin_code);
      if (done) done_cnt++;
   end

   task automatic drive_req(input logic [2:0] amt);
      @(posedge clk); #2;
      req_valid  = 1'b1;
      req_amount = amt;
      @(posedge clk); #2;
      req_valid  = 1'b0;
      req_amount = 3'd0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #2;
      fault_clr = 1'b1;
      @(posedge clk); #2;
      fault_clr = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((busy || (m_rem != 0)) && (n < 60)) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " idle bound"}, 32'(n < 60), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   // Expected codes packed two bits per coin, first coin in the LSBs.
   task automatic expect_coins(input string nm, input int n, input logic [7:0] exp_codes);
      chk({nm, " coin count"}, 32'(coin_log.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         chk({nm, " coin"}, (i < coin_log.size()) ? 32'(coin_log[i]) : 32'hF, 32'(exp_codes[2*i +: 2]));
      end
      coin_log.delete();
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, " coin_valid"}, 32'(coin_valid), 32'd0);
      chk({nm, " coin_code"}, 32'(coin_code), 32'd0);
      chk({nm, " busy"}, 32'(busy), 32'd0);
      chk({nm, " done"}, 32'(done), 32'd0);
      chk({nm, " fault"}, 32'(fault), 32'd0);
      chk({nm, " overflow"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      int d0;
      int n;

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #2;
      rst_n = 1'b1;

      // Amount 3, ack one cycle after request: two then one.
      hop_mode = 1;
      d0 = done_cnt;
      drive_req(3'd3);
      @(negedge clk);
      chk("t1 first coin valid", 32'(coin_valid), 32'd1);
      chk("t1 first coin code", 32'(coin_code), 32'd1);
      wait_idle("t1");
      expect_coins("t1", 2, 8'b0000_0001);
      chk("t1 done count", 32'(done_cnt - d0), 32'd1);

      // Amount 4, zero-latency ack.
      hop_mode = 0;
      d0 = done_cnt;
      drive_req(3'd4);
      wait_idle("t2");
      expect_coins("t2", 2, 8'b0000_0101);
      chk("t2 done count", 32'(done_cnt - d0), 32'd1);

      // Pend a 1 behind a 4, then a 2 that overflows.
      hop_mode = 1;
      d0 = done_cnt;
      drive_req(3'd4);
      drive_req(3'd1);
      drive_req(3'd2);
      @(negedge clk);
      chk("t3 overflow set", 32'(overflow), 32'd1);
      n = 0;
      while (!done && n < 40) begin @(negedge clk); n++; end
      chk("t3 done bound", 32'(n < 40), 32'd1);
      chk("t3 chained coin valid", 32'(coin_valid), 32'd1);
      chk("t3 chained coin code", 32'(coin_code), 32'd0);
      wait_idle("t3");
      expect_coins("t3", 3, 8'b0000_0101);
      chk("t3 done count", 32'(done_cnt - d0), 32'd2);
      pulse_clr();
      @(negedge clk);
      chk("t3 overflow cleared", 32'(overflow), 32'd0);

      // New request coincident with the final ack chains immediately.
      hop_mode = 0;
      d0 = done_cnt;
      drive_req(3'd1);
      req_valid  = 1'b1;
      req_amount = 3'd2;
      @(posedge clk); #2;
      req_valid  = 1'b0;
      req_amount = 3'd0;
      wait_idle("t4");
      expect_coins("t4", 2, 8'b0000_0100);
      chk("t4 done count", 32'(done_cnt - d0), 32'd2);

      // Ack in the same cycle the timeout would be reached.
      hop_mode = 2;
      d0 = done_cnt;
      drive_req(3'd1);
      wait_idle("t5");
      chk("t5 no fault", 32'(fault), 32'd0);
      expect_coins("t5", 1, 8'b0000_0000);
      chk("t5 done count", 32'(done_cnt - d0), 32'd1);

      // Stalled hopper: fault four cycles after the request.
      hop_mode = -1;
      d0 = done_cnt;
      drive_req(3'd2);
      repeat (3) @(negedge clk);
      chk("t6 fault before timeout", 32'(fault), 32'd0);
      @(negedge clk);
      chk("t6 fault at timeout", 32'(fault), 32'd1);
      chk("t6 coin_valid in fault", 32'(coin_valid), 32'd0);
      chk("t6 busy in fault", 32'(busy), 32'd1);
      drive_req(3'd5);
      @(negedge clk);
      chk("t6 req ignored busy", 32'(busy), 32'd1);
      chk("t6 req ignored coin_valid", 32'(coin_valid), 32'd0);
      pulse_clr();
      @(negedge clk);
      chk("t6 cleared busy", 32'(busy), 32'd0);
      chk("t6 cleared fault", 32'(fault), 32'd0);
      expect_coins("t6", 0, 8'b0);
      chk("t6 done count", 32'(done_cnt - d0), 32'd0);

      // Zero amount and a stray ack while idle.
      hop_mode = 1;
      d0 = done_cnt;
      drive_req(3'd0);
      ack_force = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      ack_force = 1'b0;
      @(negedge clk);
      chk("t7 busy", 32'(busy), 32'd0);
      chk("t7 coin_valid", 32'(coin_valid), 32'd0);
      expect_coins("t7", 0, 8'b0);
      chk("t7 done count", 32'(done_cnt - d0), 32'd0);

      // Reset in the middle of a payout of 4.
      d0 = done_cnt;
      drive_req(3'd4);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("t8 reset");
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("t8 no done after reset", 32'(done_cnt - d0), 32'd0);
      chk("t8 busy", 32'(busy), 32'd0);
      expect_coins("t8", 1, 8'b0000_0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog at %0t: got running expected finished", $time);
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/vm_change_dispenser.md
# vm_change_dispenser

Pays out the change owed by the vending-machine controller. It accepts a change amount in coin units and drives the coin hopper one coin at a time over a valid/ack handshake, using 2-unit coins first and then 1-unit coins. It sits between the controller's change output and the physical hopper. It buffers one pending request and detects a stalled hopper with a timeout.

## Interface
- `TIMEOUT`, default 15: cycles allowed for `coin_ack` after `coin_valid` rises before a fault is declared; legal range 1–255.
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, 1: single-cycle pulse requesting a payout of `req_amount`.
- `req_amount`, input, 3: change owed, in units, 0–7.
- `coin_valid`, output, 1: a coin is being requested from the hopper.
- `coin_code`, output, 2: coin denomination; 2'b00 = one unit, 2'b01 = two units; 2'b10 (five) is never issued.
- `coin_ack`, input, 1: hopper has released the requested coin.
- `busy`, output, 1: dispenser is not idle (state ≠ IDLE).
- `done`, output, 1: one-cycle pulse on the cycle after the final coin of a request is acknowledged.
- `fault`, output, 1: sticky flag set on hopper timeout.
- `overflow`, output, 1: sticky flag set when a request is dropped because the pending slot is full.
- `fault_clr`, input, 1: clears `fault` and `overflow` and returns the block from FAULT to IDLE.

## Operation
- State machine: IDLE, ISSUE, GAP, FAULT.
- IDLE:
  - `req_valid` with a non-zero amount loads `remaining` and moves to ISSUE.
  - An amount of 0 is ignored: no coins, no `done`.
- ISSUE:
  - `coin_valid` is 1.
  - `coin_code` is two units when `remaining` ≥ 2, otherwise one unit; it is held stable until acknowledged.
  - On `coin_ack`, `remaining` is decremented by the coin value. If the result is non-zero, go to GAP; if zero, the request is complete.
- GAP: `coin_valid` is 0 for exactly one cycle, then return to ISSUE.
- Completion:
  - `done` pulses.
  - If the pending slot is full, its amount is loaded into `remaining`, the slot is cleared, and the state goes to ISSUE without passing through IDLE. Otherwise the state goes to IDLE.
- Pending slot (one entry):
  - A non-zero `req_valid` while in ISSUE or GAP is captured if the slot is empty.
  - If the slot is full, the request is dropped and `overflow` is set.
- Timeout:
  - The wait counter clears on entry to ISSUE and increments on every ISSUE cycle without `coin_ack`.
  - When the counter reaches `TIMEOUT`, go to FAULT.
- FAULT:
  - `coin_valid` is 0, `fault` is 1, `busy` is 1.
  - `remaining` and the pending slot are cleared.
  - `req_valid` is ignored.
  - `fault_clr` moves to IDLE.
- `coin_ack` while `coin_valid` is 0 is ignored.
- `fault_clr` outside FAULT clears only `overflow`.
- Arithmetic: `remaining` is 3 bits and never underflows, because a two-unit coin is issued only when `remaining` ≥ 2.

## Timing
- Reset values: state IDLE, `coin_valid` 0, `coin_code` 2'b00, `busy` 0, `done` 0, `fault` 0, `overflow` 0, `remaining` 0, pending slot empty, wait counter 0.
- Reset asserted mid-payout aborts immediately; no `done` is produced.
- Latency: `req_valid` in cycle N gives `coin_valid` = 1 in cycle N+1. All outputs are registered.
- Ack in cycle M:
  - If more coins remain, `coin_valid` is 0 in M+1 and 1 in M+2.
  - If it was the last coin, `done` = 1 in M+1.
- Timeout: without any ack, `coin_valid` rises in cycle N+1 and FAULT is entered so that `fault` = 1 in cycle N+1+`TIMEOUT`.
- Simultaneous events:
  - `req_valid` in the same cycle as the final `coin_ack` is written into the pending slot; chaining then applies.
  - `coin_ack` in the same cycle as the timeout count being reached: the ack wins.

## Structure
- Shared package `vm_pkg`:
  - Coin code constants `COIN_ONE` = 2'b00, `COIN_TWO` = 2'b01, `COIN_FIVE` = 2'b10, shared with the controller.
  - Dispenser state enum.
  - Width constant `CHANGE_W` = 3.
- One sub-module, `vm_timeout_ctr`: an 8-bit wait counter with `clear` and `enable` inputs and an `expired` output, compared against `TIMEOUT`.

## Test plan
- Request amount 3, hopper acks one cycle after each `coin_valid` → coins issued: two, then one; one GAP cycle between them; `done` once; `busy` falls with `done`.
- Request amount 4 with zero-latency ack → coins two, two; `done` in the cycle after the second ack.
- Request 1 while paying out 4, then a request of 2 → the 1 is pended, the 2 sets `overflow`; after the first `done`, coin one is issued immediately and a second `done` follows.
- `TIMEOUT`=3, request 2, hopper never acks → `fault` = 1 four cycles after `req_valid`; `coin_valid` = 0; a further `req_valid` is ignored; `fault_clr` returns the block to IDLE with `busy` = 0.
- Request 0, and `coin_ack` asserted while idle → no coins, no `done`, no state change.
- `rst_n` low mid-payout of amount 4 → all outputs return to reset values asynchronously; no `done` is produced after reset is released.
